// File: rtl/vebpf_call_arbiter.sv
// -----------------------------------------------------------------------------
// vebpf_call_arbiter
//
// Collects helper-function calls from NUM_CORE cores and forwards them one at a
// time to the vEBPF scheduler. Each core owns a single pending slot (fid plus
// three 64-bit arguments). Slots are granted round-robin, starting after the
// last core served. Only one call is outstanding to the scheduler at any time.
//
// Optional feature: define VEBPF_ARB_TIMEOUT_EN to add a WAIT-state watchdog.
// After TIMEOUT_CYCLES WAIT cycles with no result, the call completes with
// core_r0 = all ones and a one-cycle arb_err pulse.
//
// Ports
//   clk              clock, all logic on the rising edge
//   rst              asynchronous active-high reset
//   core_req         per-core call strobe
//   core_fid         per-core function id, core 0 in the LSBs
//   core_r1..r3      per-core 64-bit arguments, core 0 in the LSBs
//   core_busy        per-core pending slot occupied
//   core_r0          returned value, shared by all cores
//   core_r0_valid    one-hot return strobe
//   vebpf_core_req   function id to the scheduler
//   vebpf_request    one-cycle call strobe to the scheduler
//   vebpf_r1..r3     call arguments to the scheduler
//   vebpf_r0         scheduler result
//   vebpf_r0_valid   scheduler result strobe
//   vebpf_core_resp  scheduler response flag (not used)
//   arb_err          timeout error pulse (VEBPF_ARB_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module vebpf_call_arbiter #(
   parameter int NUM_CORE          = 4,
   parameter int FUNCTION_ID_WIDTH = 8,
   parameter int TIMEOUT_CYCLES    = 1024
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [NUM_CORE-1:0]                 core_req,
   input  logic [NUM_CORE*FUNCTION_ID_WIDTH-1:0] core_fid,
   input  logic [NUM_CORE*64-1:0]              core_r1,
   input  logic [NUM_CORE*64-1:0]              core_r2,
   input  logic [NUM_CORE*64-1:0]              core_r3,
   output logic [NUM_CORE-1:0]                 core_busy,
   output logic [63:0]                         core_r0,
   output logic [NUM_CORE-1:0]                 core_r0_valid,
   output logic [FUNCTION_ID_WIDTH-1:0]        vebpf_core_req,
   output logic                                vebpf_request,
   output logic [63:0]                         vebpf_r1,
   output logic [63:0]                         vebpf_r2,
   output logic [63:0]                         vebpf_r3,
   input  logic [63:0]                         vebpf_r0,
   input  logic                                vebpf_r0_valid,
   input  logic                                vebpf_core_resp
`ifdef VEBPF_ARB_TIMEOUT_EN
   ,
   output logic                                arb_err
`endif
);

   localparam int FW    = FUNCTION_ID_WIDTH;
   localparam int IDX_W = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t                 state_q, state_d;

   logic [NUM_CORE-1:0]    valid_q, valid_d;
   logic [FW-1:0]          fid_q [NUM_CORE];
   logic [63:0]            r1_q  [NUM_CORE];
   logic [63:0]            r2_q  [NUM_CORE];
   logic [63:0]            r3_q  [NUM_CORE];

   logic [IDX_W-1:0]       grant_q;
   logic [IDX_W-1:0]       last_grant_q;
   logic [IDX_W-1:0]       pick_idx;
   logic [IDX_W-1:0]       cand;
   logic                   pick_vld;

   logic [FW-1:0]          vebpf_fid_q;
   logic [63:0]            vebpf_r1_q, vebpf_r2_q, vebpf_r3_q;
   logic [63:0]            core_r0_q;

   logic                   unused_resp;
   assign unused_resp = vebpf_core_resp;

`ifdef VEBPF_ARB_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [CNT_W-1:0]       wait_cnt_q;
   logic                   err_q;
   logic                   tmo;

   // A result on the final WAIT cycle takes priority over the timeout.
   assign tmo = (state_q == S_WAIT) && !vebpf_r0_valid &&
                (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0]            unused_tmo;
   assign unused_tmo = 32'(TIMEOUT_CYCLES);
`endif

   // Round-robin pick: scan downward so the last hit is the slot closest
   // after last_grant, i.e. the first one in round-robin order.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = '0;
      for (int off = NUM_CORE; off >= 1; off--) begin
         cand = IDX_W'((int'(last_grant_q) + off) % NUM_CORE);
         if (valid_q[cand]) begin
            pick_vld = 1'b1;
            pick_idx = cand;
         end
      end
   end

   // Slot valid flags: captures for free slots run independently of the FSM;
   // the granted slot is released on the edge that leaves RESP.
   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < NUM_CORE; i++) begin
         if (core_req[i] && !valid_q[i]) valid_d[i] = 1'b1;
      end
      if (state_q == S_RESP) valid_d[grant_q] = 1'b0;
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pick_vld) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            if (vebpf_r0_valid) state_d = S_RESP;
`ifdef VEBPF_ARB_TIMEOUT_EN
            else if (tmo)       state_d = S_RESP;
`endif
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      vebpf_request = (state_q == S_ISSUE);
      core_r0_valid = '0;
      if (state_q == S_RESP) core_r0_valid[grant_q] = 1'b1;
`ifdef VEBPF_ARB_TIMEOUT_EN
      arb_err = (state_q == S_RESP) && err_q;
`endif
   end

   // Control and output registers; all cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= '0;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(NUM_CORE - 1);
         vebpf_fid_q  <= '0;
         vebpf_r1_q   <= '0;
         vebpf_r2_q   <= '0;
         vebpf_r3_q   <= '0;
         core_r0_q    <= '0;
      end else begin
         valid_q <= valid_d;
         if (state_q == S_IDLE && pick_vld) begin
            grant_q     <= pick_idx;
            vebpf_fid_q <= fid_q[pick_idx];
            vebpf_r1_q  <= r1_q[pick_idx];
            vebpf_r2_q  <= r2_q[pick_idx];
            vebpf_r3_q  <= r3_q[pick_idx];
         end
         if (state_q == S_WAIT) begin
            if (vebpf_r0_valid) core_r0_q <= vebpf_r0;
`ifdef VEBPF_ARB_TIMEOUT_EN
            else if (tmo)       core_r0_q <= '1;
`endif
         end
         if (state_q == S_RESP) last_grant_q <= grant_q;
      end
   end

`ifdef VEBPF_ARB_TIMEOUT_EN
   // Watchdog counts WAIT cycles; err_q marks a call that ended by timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 1'b1 : '0;
         err_q      <= tmo;
      end
   end
`endif

   // Slot payload; only meaningful while the matching valid flag is set.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CORE; i++) begin
         if (core_req[i] && !valid_q[i]) begin
            fid_q[i] <= core_fid[i*FW +: FW];
            r1_q[i]  <= core_r1[i*64 +: 64];
            r2_q[i]  <= core_r2[i*64 +: 64];
            r3_q[i]  <= core_r3[i*64 +: 64];
         end
      end
   end

   assign core_busy      = valid_q;
   assign core_r0        = core_r0_q;
   assign vebpf_core_req = vebpf_fid_q;
   assign vebpf_r1       = vebpf_r1_q;
   assign vebpf_r2       = vebpf_r2_q;
   assign vebpf_r3       = vebpf_r3_q;

endmodule
